ahb_dma_master: RTL and testbench

Single-channel AHB-Lite initiator that copies a block of 32-bit words from a source address to a destination address. It plugs into an unused master port of the AHB bus matrix alongside the riscv32ia load/store port. It reaches the dcache and GPIO responders through the same address decode as the core. Software-visible control is a simple command strobe; the block issues only single-beat NONSEQ transfers.

---
 rtl/ahb_dma_master.sv | 219 +++++++++++++++++++++
 tb/tb_ahb_dma_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_dma_master.sv
// ahb_dma_master
// Single-channel AHB-Lite initiator. It copies len_words 32-bit words from
// src_addr to dst_addr using single-beat NONSEQ transfers. Only one transfer
// is in flight at a time, so a zero-wait copy takes 4 cycles per word.
//
// Optional feature: define DMA_FILL_MODE_EN to enable pattern fill. When
// fill_mode=1 at start, every write carries fill_data and no reads are issued.
// When the macro is undefined, fill_mode and fill_data are ignored.
//
// Ports:
//   CLK, RST              clock; synchronous active-high reset
//   start                 command strobe, sampled only in IDLE
//   src_addr, dst_addr    byte addresses; bits [1:0] are forced to 0
//   len_words             number of words to move
//   src_inc, dst_inc      1 = advance the address by 4 per word
//   fill_mode, fill_data  pattern fill request and pattern
//   busy, done, err       status; done and err are one-cycle pulses
//   words_done            count of completed writes; holds after completion
//   haddr..hmastlock      AHB-Lite master outputs
//   hrdata, hready, hresp AHB-Lite master inputs
module ahb_dma_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len_words,
    input  logic                  src_inc,
    input  logic                  dst_inc,
    input  logic                  fill_mode,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  words_done,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hwrite,
    output logic [1:0]            htrans,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [3:0]            hprot,
    output logic                  hmastlock,
    input  logic                  hready,
    input  logic                  hresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR,
        S_WR_DATA,
        S_FIN
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  wdone_q, wdone_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;   // read holding register / fill pattern
    logic                  sinc_q, sinc_d;
    logic                  dinc_q, dinc_d;
    logic                  fill_q, fill_d;
    logic                  err_q, err_d;
    logic                  fill_start;
    logic [LEN_WIDTH-1:0]  wdone_inc;

`ifdef DMA_FILL_MODE_EN
    assign fill_start = fill_mode;
    logic unused_ok;
    assign unused_ok = ^{src_addr[1:0], dst_addr[1:0]};
`else
    assign fill_start = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{src_addr[1:0], dst_addr[1:0], fill_mode, fill_data};
`endif

    assign wdone_inc = wdone_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            wdone_q <= '0;
            data_q  <= '0;
            sinc_q  <= 1'b0;
            dinc_q  <= 1'b0;
            fill_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            wdone_q <= wdone_d;
            data_q  <= data_d;
            sinc_q  <= sinc_d;
            dinc_q  <= dinc_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        wdone_d = wdone_q;
        data_d  = data_q;
        sinc_d  = sinc_q;
        dinc_d  = dinc_q;
        fill_d  = fill_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = {src_addr[ADDR_WIDTH-1:2], 2'b00};
                    dst_d   = {dst_addr[ADDR_WIDTH-1:2], 2'b00};
                    len_d   = len_words;
                    sinc_d  = src_inc;
                    dinc_d  = dst_inc;
                    fill_d  = fill_start;
                    wdone_d = '0;
                    if (fill_start) begin
                        data_d = fill_data;
                    end
                    if (len_words == '0) begin
                        state_d = S_FIN;
                    end else if (fill_start) begin
                        state_d = S_WR_ADDR;
                    end else begin
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                if (hready) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                // First cycle of a two-cycle ERROR response aborts; htrans is
                // already IDLE so the second cycle needs nothing from us.
                if (hresp) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (hready) begin
                    data_d  = hrdata;
                    state_d = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                if (hready) begin
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (hresp) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (hready) begin
                    wdone_d = wdone_inc;
                    // Fill never reads, so the source pointer stays put.
                    if (sinc_q && !fill_q) begin
                        src_d = src_q + ADDR_WIDTH'(4);
                    end
                    if (dinc_q) begin
                        dst_d = dst_q + ADDR_WIDTH'(4);
                    end
                    if (wdone_inc < len_q) begin
                        state_d = fill_q ? S_WR_ADDR : S_RD_ADDR;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state; the state register holds them
    // steady across wait states.
    assign busy       = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA) ||
                        (state_q == S_WR_ADDR) || (state_q == S_WR_DATA);
    assign done       = (state_q == S_FIN);
    assign err        = err_q;
    assign words_done = wdone_q;

    assign htrans     = ((state_q == S_RD_ADDR) || (state_q == S_WR_ADDR)) ?
                        HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr      = (state_q == S_RD_ADDR) ? src_q :
                        (state_q == S_WR_ADDR) ? dst_q : '0;
    assign hwrite     = (state_q == S_WR_ADDR);
    assign hwdata     = data_q;
    assign hsize      = 3'b010;
    assign hburst     = 3'b000;
    assign hprot      = 4'b0011;
    assign hmastlock  = 1'b0;

endmodule

// File: tb/tb_ahb_dma_master.sv
module tb_ahb_dma_master;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0, fill_data = '0;
    logic [15:0] len_words = '0;
    logic        src_inc = 1'b0, dst_inc = 1'b0, fill_mode = 1'b0;
    logic        busy, done, err, hwrite, hmastlock;
    logic [15:0] words_done;
    logic [31:0] haddr, hwdata;
    logic [31:0] hrdata = '0;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hready = 1'b1, hresp = 1'b0;

    int tests_run = 0, tests_failed = 0;

    always #5 CLK = ~CLK;

    ahb_dma_master dut (
        .CLK(CLK), .RST(RST), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len_words(len_words), .src_inc(src_inc), .dst_inc(dst_inc),
        .fill_mode(fill_mode), .fill_data(fill_data), .busy(busy), .done(done), .err(err),
        .words_done(words_done), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
        .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hready(hready), .hresp(hresp)
    );

    // ---------------- responder: memory-less slave with wait states / error ----------
    int          aws = 0, dws = 0, err_at = -1;
    logic [31:0] salt = '0;
    bit          dp_active = 0, dp_write = 0, dp_first = 0, dp_done_drv = 0, acc_drv = 0;
    int          cnt = 0, err_stage = 0, wr_idx = 0;
    int          nonseq_cnt = 0, stab_err = 0, overlap_err = 0;
    logic [31:0] dp_addr, dp_wfirst, s_haddr, s_hwdata;
    logic        s_hwrite;
    logic [31:0] wlog_a[$], wlog_d[$], rlog_a[$];

    function automatic logic [31:0] rdval(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ salt;
    endfunction

    always @(negedge CLK) begin
        if (RST) begin
            dp_active = 0; dp_done_drv = 0; acc_drv = 0; cnt = 0; err_stage = 0;
            hready = 1'b1; hresp = 1'b0;
        end else begin
            // retire what the previous rising edge completed
            if (dp_done_drv) begin
                if (dp_write) begin
                    wlog_a.push_back(dp_addr); wlog_d.push_back(s_hwdata); wr_idx++;
                end else rlog_a.push_back(dp_addr);
                dp_active = 0; cnt = 0;
            end
            if (acc_drv) begin
                dp_active = 1; dp_addr = s_haddr; dp_write = s_hwrite; dp_first = 1; cnt = 0;
            end
            if (err_stage == 2) begin
                dp_active = 0; err_stage = 0; cnt = 0;
            end
            dp_done_drv = 0; acc_drv = 0;
            hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
            if (err_stage == 1) begin
                err_stage = 2; hresp = 1'b1; hready = 1'b1;
            end else if (dp_active) begin
                if (htrans == 2'b10) overlap_err++;
                if (dp_write) begin
                    if (dp_first) dp_wfirst = hwdata;
                    else if (hwdata !== dp_wfirst) stab_err++;
                end
                dp_first = 0;
                if (dp_write && wr_idx == err_at) begin
                    err_stage = 1; hready = 1'b0; hresp = 1'b1;
                end else if (cnt < dws) begin
                    cnt++; hready = 1'b0;
                end else begin
                    dp_done_drv = 1; s_hwdata = hwdata;
                    if (!dp_write) hrdata = rdval(dp_addr);
                end
            end else if (htrans == 2'b10) begin
                if (cnt == 0) begin
                    s_haddr = haddr; s_hwrite = hwrite;
                end else if (haddr !== s_haddr || hwrite !== s_hwrite) stab_err++;
                if (cnt < aws) begin
                    cnt++; hready = 1'b0;
                end else begin
                    acc_drv = 1; nonseq_cnt++;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer: drive the command, then compare against a word-level model.
    task automatic run(input string nm, input logic [31:0] src, input logic [31:0] dst,
                       input int len, input bit si, input bit di, input bit fm,
                       input logic [31:0] fd, input int a_ws, input int d_ws, input int e_at);
        int cyc, done_cyc, ndone, nerr, extra;
        bit busy_bad, fill_eff, is_err;
        int exp_w, exp_r, exp_cyc;
        logic [31:0] s0, d0, ea;
        aws = a_ws; dws = d_ws; err_at = e_at; wr_idx = 0; salt = $urandom;
        wlog_a.delete(); wlog_d.delete(); rlog_a.delete();
        nonseq_cnt = 0; stab_err = 0; overlap_err = 0;
        src_addr = src; dst_addr = dst; len_words = 16'(len);
        src_inc = si; dst_inc = di; fill_mode = fm; fill_data = fd; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        done_cyc = 0; ndone = 0; nerr = 0; busy_bad = 0;
        for (cyc = 1; cyc <= 3000; cyc++) begin
            if (done) begin ndone++; done_cyc = cyc; end
            if (err) nerr++;
            if (done || err) break;
            if (busy !== 1'b1) busy_bad = 1;
            // command inputs are free to change; start while busy is ignored
            start = 1'($urandom_range(0, 1));
            src_addr = $urandom; dst_addr = $urandom; len_words = 16'($urandom);
            src_inc = 1'($urandom); dst_inc = 1'($urandom);
            fill_mode = 1'($urandom); fill_data = $urandom;
            @(negedge CLK);
        end
        start = 1'b0;
        chk({nm, ".timeout"}, 32'(cyc > 3000), 32'd0);
        if (cyc > 3000) begin
            RST = 1'b1; @(negedge CLK); RST = 1'b0;
        end
        if (len != 0) chk({nm, ".busy_end"}, 32'(busy), 32'd0);
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (done || err || busy || htrans != 2'b00) extra++;
        end
        // ---- reference: word-level description of the transfer ----
`ifdef DMA_FILL_MODE_EN
        fill_eff = fm;
`else
        fill_eff = 0;
`endif
        is_err  = (e_at >= 0) && (e_at < len);
        exp_w   = is_err ? e_at : len;
        exp_r   = fill_eff ? 0 : (is_err ? e_at + 1 : len);
        exp_cyc = 1 + len * (fill_eff ? (2 + a_ws + d_ws) : (4 + 2 * a_ws + 2 * d_ws));
        s0 = src & 32'hFFFF_FFFC;
        d0 = dst & 32'hFFFF_FFFC;
        chk({nm, ".done_cnt"}, 32'(ndone), is_err ? 32'd0 : 32'd1);
        chk({nm, ".err_cnt"}, 32'(nerr), is_err ? 32'd1 : 32'd0);
        if (!is_err) chk({nm, ".done_cyc"}, 32'(done_cyc), 32'(exp_cyc));
        chk({nm, ".extra_pulses"}, 32'(extra), 32'd0);
        if (len != 0) chk({nm, ".busy"}, 32'(busy_bad), 32'd0);
        chk({nm, ".words_done"}, 32'(words_done), 32'(exp_w));
        chk({nm, ".n_writes"}, 32'(wlog_a.size()), 32'(exp_w));
        chk({nm, ".n_reads"}, 32'(rlog_a.size()), 32'(exp_r));
        chk({nm, ".n_nonseq"}, 32'(nonseq_cnt), 32'(exp_r + (is_err ? e_at + 1 : len)));
        chk({nm, ".stable"}, 32'(stab_err), 32'd0);
        chk({nm, ".overlap"}, 32'(overlap_err), 32'd0);
        for (int i = 0; i < exp_w && i < wlog_a.size(); i++) begin
            chk($sformatf("%s.waddr%0d", nm, i), wlog_a[i], d0 + (di ? 32'(4 * i) : 32'd0));
            ea = s0 + (si ? 32'(4 * i) : 32'd0);
            chk($sformatf("%s.wdata%0d", nm, i), wlog_d[i], fill_eff ? fd : rdval(ea));
        end
        for (int i = 0; i < exp_r && i < rlog_a.size(); i++)
            chk($sformatf("%s.raddr%0d", nm, i), rlog_a[i], s0 + (si ? 32'(4 * i) : 32'd0));
    endtask

    initial begin
        int nonseq_seen, dn;
        // ---- reset state ----
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("rst.busy", 32'(busy), 0);     chk("rst.done", 32'(done), 0);
        chk("rst.err", 32'(err), 0);       chk("rst.words", 32'(words_done), 0);
        chk("rst.htrans", 32'(htrans), 0); chk("rst.hwrite", 32'(hwrite), 0);
        chk("rst.haddr", haddr, 0);        chk("rst.hwdata", hwdata, 0);
        chk("const.hsize", 32'(hsize), 32'd2);   chk("const.hburst", 32'(hburst), 0);
        chk("const.hprot", 32'(hprot), 32'd3);   chk("const.hmastlock", 32'(hmastlock), 0);

        // ---- directed ----
        run("copy4", 32'h8000, 32'h8100, 4, 1, 1, 0, 0, 0, 0, -1);
        run("len0", 32'h8000, 32'h8100, 0, 1, 1, 0, 0, 0, 0, -1);
        run("waits", 32'h2000_0000, 32'h2000_0400, 5, 1, 1, 0, 0, 2, 3, -1);
        run("wr_err", 32'h8000, 32'h8200, 5, 1, 1, 0, 0, 0, 0, 2);
        run("gpio", 32'h8000, 32'hFFFF_8000, 3, 1, 0, 0, 0, 0, 0, -1);
        run("wrap", 32'hFFFF_FFFC, 32'h9000, 2, 1, 1, 0, 0, 0, 0, -1);
        run("fill", 32'h1000, 32'h8300, 2, 1, 1, 1, 32'hDEAD_BEEF, 0, 0, -1);
        run("lowbits", 32'h8003, 32'h8102, 2, 1, 1, 0, 0, 1, 0, -1);
        run("fixsrc", 32'h4000_0010, 32'h8000, 3, 0, 1, 0, 0, 0, 1, -1);

        // ---- randomized ----
        for (int t = 0; t < 10; t++) begin
            int l, e;
            l = $urandom_range(1, 8);
            e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, l - 1) : -1;
            run($sformatf("rnd%0d", t), $urandom, $urandom, l, 1'($urandom), 1'($urandom),
                1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3), e);
        end

        // ---- reset in the middle of a transfer ----
        aws = 0; dws = 0; err_at = -1; wr_idx = 0;
        src_addr = 32'h8000; dst_addr = 32'h8100; len_words = 16'd8;
        src_inc = 1; dst_inc = 1; fill_mode = 0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        chk("midrst.words_before", 32'(words_done), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("midrst.htrans", 32'(htrans), 0);
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.words", 32'(words_done), 0);
        nonseq_seen = 0; dn = 0;
        for (int k = 0; k < 12; k++) begin
            if (htrans != 2'b00) nonseq_seen++;
            if (done || err) dn++;
            @(negedge CLK);
        end
        chk("midrst.quiet_bus", 32'(nonseq_seen), 0);
        chk("midrst.no_pulse", 32'(dn), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
